// File: rtl/sample_sequencer.sv
// Pattern step sequencer: walks STEPS programmable {gate, freq} entries at a tempo given in
// clock cycles and emits a one-cycle trigger plus pitch word for the sample player.
module sample_sequencer #(
    parameter int unsigned STEPS   = 16,
    parameter int unsigned TEMPO_W = 24
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [TEMPO_W-1:0]       tempo_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(STEPS)-1:0] wr_addr_i,
    input  logic                     wr_gate_i,
    input  logic [15:0]              wr_freq_i,
    output logic                     trig_o,
    output logic [15:0]              freq_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic                     running_o
);

    localparam int unsigned AW = $clog2(STEPS);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q;
    logic [STEPS-1:0]    gate_q;
    logic [15:0]         freq_mem_q [STEPS];
    logic [TEMPO_W-1:0]  tick_q;
    logic [TEMPO_W-1:0]  tick_max;
    logic [AW-1:0]       step_q;
    logic [AW-1:0]       step_nxt;
    logic                trig_q;
    logic [15:0]         freq_q;
    logic                running_q;

    // Tempo 0 behaves as 1, so the last tick index is 0 in both cases.
    assign tick_max = (tempo_i == '0) ? '0 : tempo_i - TEMPO_W'(1);
    assign step_nxt = step_q + AW'(1);

    // Pattern reads below see the pre-write contents in the write cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gate_q <= '0;
            for (int i = 0; i < STEPS; i++) begin
                freq_mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            gate_q[wr_addr_i]     <= wr_gate_i;
            freq_mem_q[wr_addr_i] <= wr_freq_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            step_q    <= '0;
            trig_q    <= 1'b0;
            freq_q    <= '0;
            running_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tick_q <= '0;
                    step_q <= '0;
                    trig_q <= 1'b0;
                    if (start_i && !stop_i) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                        trig_q    <= gate_q[0];
                        if (gate_q[0]) begin
                            freq_q <= freq_mem_q[0];
                        end
                    end
                end
                StRun: begin
                    if (stop_i) begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                        tick_q    <= '0;
                        step_q    <= '0;
                        trig_q    <= 1'b0;
                    end else if (start_i) begin
                        tick_q <= '0;
                        step_q <= '0;
                        trig_q <= gate_q[0];
                        if (gate_q[0]) begin
                            freq_q <= freq_mem_q[0];
                        end
                    end else if (tick_q >= tick_max) begin
                        // >= so a tempo cut below the current tick advances at once.
                        tick_q <= '0;
                        step_q <= step_nxt;
                        trig_q <= gate_q[step_nxt];
                        if (gate_q[step_nxt]) begin
                            freq_q <= freq_mem_q[step_nxt];
                        end
                    end else begin
                        tick_q <= tick_q + TEMPO_W'(1);
                        trig_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign trig_o    = trig_q;
    assign freq_o    = freq_q;
    assign step_o    = step_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed self-checking bench for sample_sequencer; cycle N is the interval just after
// clock edge N, with inputs driven and outputs sampled 1 ns after the edge.
module tb_sample_sequencer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        stop_i;
    logic [23:0] tempo_i;
    logic        wr_en_i;
    logic [3:0]  wr_addr_i;
    logic        wr_gate_i;
    logic [15:0] wr_freq_i;
    logic        trig_o;
    logic [15:0] freq_o;
    logic [3:0]  step_o;
    logic        running_o;

    int tests = 0;
    int fails = 0;

    sample_sequencer #(.STEPS(16), .TEMPO_W(24)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .tempo_i   (tempo_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_gate_i (wr_gate_i),
        .wr_freq_i (wr_freq_i),
        .trig_o    (trig_o),
        .freq_o    (freq_o),
        .step_o    (step_o),
        .running_o (running_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic gate, input logic [15:0] freq);
        wr_en_i   = 1'b1;
        wr_addr_i = addr;
        wr_gate_i = gate;
        wr_freq_i = freq;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    initial begin
        int trig_cnt;
        int st;
        logic exp_trig;

        rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; tempo_i = '0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_gate_i = 1'b0; wr_freq_i = '0;
        tick(3);
        check("rst_trig", 32'(trig_o), 0);
        check("rst_freq", 32'(freq_o), 0);
        check("rst_step", 32'(step_o), 0);
        check("rst_running", 32'(running_o), 0);
        rstn_i = 1'b1;

        // Idle with no start: never a trigger
        trig_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (trig_o) trig_cnt++;
        end
        check("idle_no_trig", 32'(trig_cnt), 0);
        check("idle_step", 32'(step_o), 0);
        check("idle_running", 32'(running_o), 0);

        // Basic run, tempo 4, steps 0 and 2 gated
        wr(4'd0, 1'b1, 16'h1000);
        wr(4'd2, 1'b1, 16'h2000);
        check("wr_no_trig", 32'(trig_o), 0);
        tempo_i = 24'd4;
        pulse_start();                       // now cycle 1
        check("c1_running", 32'(running_o), 1);
        check("c1_step", 32'(step_o), 0);
        check("c1_trig", 32'(trig_o), 1);
        check("c1_freq", 32'(freq_o), 32'h1000);
        for (int c = 2; c <= 65; c++) begin
            tick();
            st = ((c - 1) / 4) % 16;
            exp_trig = ((c - 1) % 4 == 0) && (st == 0 || st == 2);
            check("run_step", 32'(step_o), 32'(st));
            check("run_trig", 32'(trig_o), 32'(exp_trig));
            if (c == 8)  check("c8_freq", 32'(freq_o), 32'h1000);
            if (c == 9)  check("c9_freq", 32'(freq_o), 32'h2000);
            if (c == 64) check("c64_freq", 32'(freq_o), 32'h2000);
            if (c == 65) check("c65_freq", 32'(freq_o), 32'h1000);
        end

        // Stop at step 5; freq holds step 2's pitch
        tick(20);                            // cycle 85
        check("pre_stop_step", 32'(step_o), 5);
        pulse_stop();
        check("stop_running", 32'(running_o), 0);
        check("stop_step", 32'(step_o), 0);
        check("stop_trig", 32'(trig_o), 0);
        check("stop_freq", 32'(freq_o), 32'h2000);
        tick(5);
        check("stopped_step", 32'(step_o), 0);

        // Restart at step 7, tick 2
        pulse_start();
        check("rs_c1_trig", 32'(trig_o), 1);
        tick(30);
        check("rs_pre_step", 32'(step_o), 7);
        check("rs_pre_trig", 32'(trig_o), 0);
        pulse_start();
        check("rs_step", 32'(step_o), 0);
        check("rs_trig", 32'(trig_o), 1);
        check("rs_running", 32'(running_o), 1);
        check("rs_freq", 32'(freq_o), 32'h1000);
        tick(4);
        check("rs_full_step", 32'(step_o), 1);

        // Simultaneous start+stop while running ends in idle
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        check("ss_running", 32'(running_o), 0);
        check("ss_step", 32'(step_o), 0);
        check("ss_trig", 32'(trig_o), 0);

        // Tempo 0, all gates set: trigger every cycle
        for (int i = 0; i < 16; i++) wr(4'(i), 1'b1, 16'(16'h0100 * (i + 1)));
        tempo_i = '0;
        pulse_start();
        check("t0_step0", 32'(step_o), 0);
        check("t0_trig0", 32'(trig_o), 1);
        check("t0_freq0", 32'(freq_o), 32'h0100);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t0_step", 32'(step_o), 32'(k % 16));
            check("t0_trig", 32'(trig_o), 1);
            check("t0_freq", 32'(freq_o), 32'(16'h0100 * ((k % 16) + 1)));
        end
        pulse_stop();

        // Tempo 100 at tick 50, drop to 10: step advances next cycle
        tempo_i = 24'd100;
        pulse_start();
        tick(50);
        check("td_pre_step", 32'(step_o), 0);
        check("td_pre_trig", 32'(trig_o), 0);
        tempo_i = 24'd10;
        tick();
        check("td_step", 32'(step_o), 1);
        check("td_trig", 32'(trig_o), 1);
        check("td_freq", 32'(freq_o), 32'h0200);
        tick(9);
        check("td_hold_step", 32'(step_o), 1);
        tick();
        check("td_next_step", 32'(step_o), 2);
        pulse_stop();

        // Write step 3 in the cycle it is read: old entry now, new entry after wrap
        tempo_i = 24'd4;
        pulse_start();                       // cycle 1
        tick(11);                            // cycle 12, last of step 2
        wr(4'd3, 1'b1, 16'hABCD);            // cycle 13
        check("rw_step", 32'(step_o), 3);
        check("rw_trig", 32'(trig_o), 1);
        check("rw_old_freq", 32'(freq_o), 32'h0400);
        tick(64);                            // cycle 77
        check("rw_wrap_step", 32'(step_o), 3);
        check("rw_new_freq", 32'(freq_o), 32'hABCD);

        // Asynchronous reset mid-run acts immediately and clears the pattern
        #2 rstn_i = 1'b0;
        #1;
        check("ar_running", 32'(running_o), 0);
        check("ar_step", 32'(step_o), 0);
        check("ar_freq", 32'(freq_o), 0);
        check("ar_trig", 32'(trig_o), 0);
        tick();
        rstn_i = 1'b1;
        tempo_i = 24'd1;
        pulse_start();
        check("ar_gate_clr_trig", 32'(trig_o), 0);
        check("ar_run", 32'(running_o), 1);
        tick();
        check("ar_t1_step", 32'(step_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
